// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: CPU and DMA request/grant/ack handshakes plus the shared read data.
// The arbiter uses the slave modport; the requester side uses the master modport.
interface mem_arbiter_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_grant;
  logic              cpu_ack;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [WORD_W-1:0] dma_wdata;
  logic              dma_grant;
  logic              dma_ack;

  logic [WORD_W-1:0] rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output cpu_grant, cpu_ack, dma_grant, dma_ack, rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  cpu_grant, cpu_ack, dma_grant, dma_ack, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/DMA arbiter and 4-state sequencer in front of the single-port data RAM.
// Optional feature: define MEM_ARB_LOCK_EN to add i_cpu_lock (CPU bus locking for atomic RMW).
module mem_arbiter #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [WORD_W-1:0] o_ram_wdata,
  output logic              o_ram_oe,
  output logic              o_ram_we,
  input  logic [WORD_W-1:0] i_ram_rdata,
  output logic [1:0]        o_arb_state
`ifdef MEM_ARB_LOCK_EN
  ,
  input  logic              i_cpu_lock
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;   // 0 = CPU, 1 = DMA
  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rdata;

  logic w_win;
  logic w_win_dma;
  logic w_dma_req;
  logic w_dma_blocked;

`ifdef MEM_ARB_LOCK_EN
  logic r_locked;
  assign w_dma_blocked = r_locked & i_cpu_lock;
`else
  assign w_dma_blocked = 1'b0;
`endif

  // Next-state and arbitration decision; a winner is only chosen in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_win       = 1'b0;
    w_win_dma   = 1'b0;
    w_dma_req   = bus.dma_req & ~w_dma_blocked;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req && w_dma_req) begin
          w_win     = 1'b1;
          w_win_dma = ~r_last;
        end else if (bus.cpu_req) begin
          w_win     = 1'b1;
          w_win_dma = 1'b0;
        end else if (w_dma_req) begin
          w_win     = 1'b1;
          w_win_dma = 1'b1;
        end else begin
          w_win     = 1'b0;
          w_win_dma = 1'b0;
        end
        if (w_win) begin
          w_state_nxt = ST_ADDR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADDR:   w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus transaction latches, read capture and round-robin history
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= {WORD_W{1'b0}};
      r_rdata <= {WORD_W{1'b0}};
`ifdef MEM_ARB_LOCK_EN
      r_locked <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_win) begin
        r_owner <= w_win_dma;
        r_we    <= w_win_dma ? bus.dma_we    : bus.cpu_we;
        r_addr  <= w_win_dma ? bus.dma_addr  : bus.cpu_addr;
        r_wdata <= w_win_dma ? bus.dma_wdata : bus.cpu_wdata;
      end
      if ((r_state == ST_ACCESS) && !r_we) begin
        r_rdata <= i_ram_rdata;
      end
      if (r_state == ST_ACK) begin
        r_last <= r_owner;
      end
`ifdef MEM_ARB_LOCK_EN
      // Releasing the lock hands the next tie to the DMA
      if ((r_state == ST_ACK) && !r_owner && i_cpu_lock) begin
        r_locked <= 1'b1;
      end else if (r_locked && !i_cpu_lock) begin
        r_locked <= 1'b0;
        r_last   <= 1'b0;
      end
`endif
    end
  end

  assign bus.cpu_grant = (r_state != ST_IDLE) && !r_owner;
  assign bus.dma_grant = (r_state != ST_IDLE) &&  r_owner;
  assign bus.cpu_ack   = (r_state == ST_ACK)  && !r_owner;
  assign bus.dma_ack   = (r_state == ST_ACK)  &&  r_owner;
  assign bus.rdata     = r_rdata;
  assign o_ram_oe      = (r_state == ST_ACCESS) && !r_we;
  assign o_ram_we      = (r_state == ST_ACCESS) &&  r_we;
  assign o_ram_addr    = r_addr;
  assign o_ram_wdata   = r_wdata;
  assign o_arb_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM; outputs are sampled and inputs driven on the falling edge.
// Status vector layout: {arb_state[1:0], cpu_grant, dma_grant, cpu_ack, dma_ack, ram_oe, ram_we}.
module tb_mem_arbiter;
  logic        clk;
  logic        rst;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_oe;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [1:0]  arb_state;
`ifdef MEM_ARB_LOCK_EN
  logic        cpu_lock;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:65535];
  logic        pre_en;
  logic [15:0] pre_addr;
  logic [15:0] pre_data;

  mem_arbiter_if #(.WORD_W(16), .ADDR_W(16)) bus ();

  mem_arbiter #(.WORD_W(16), .ADDR_W(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .o_ram_oe    (ram_oe),
    .o_ram_we    (ram_we),
    .i_ram_rdata (ram_rdata),
    .o_arb_state (arb_state)
`ifdef MEM_ARB_LOCK_EN
    ,
    .i_cpu_lock  (cpu_lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = ram_oe ? mem[ram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  function automatic logic [7:0] outs();
    return {arb_state, bus.cpu_grant, bus.dma_grant, bus.cpu_ack, bus.dma_ack, ram_oe, ram_we};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pre_en = 1'b1; pre_addr = 16'h0040; pre_data = 16'hBEEF;
    cyc();
    pre_en = 1'b0;
    cyc();
    total++; if (outs() !== 8'b00_00_00_00) begin bad++; $display("FAIL reset_outs: got %b want %b", outs(), 8'b00_00_00_00); end
    total++; if (ram_addr !== 16'h0000 || ram_wdata !== 16'h0000) begin bad++; $display("FAIL reset_ram_bus: got addr=%h wdata=%h want 0000/0000", ram_addr, ram_wdata); end
    total++; if (bus.rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata: got %h want 0000", bus.rdata); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_cpu_read();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
    cyc();
    total++; if (outs() !== 8'b01_10_00_00) begin bad++; $display("FAIL rd_addr_phase: got %b want %b", outs(), 8'b01_10_00_00); end
    total++; if (ram_addr !== 16'h0040) begin bad++; $display("FAIL rd_ram_addr: got %h want 0040", ram_addr); end
    cyc();
    total++; if (outs() !== 8'b10_10_00_10) begin bad++; $display("FAIL rd_access_phase: got %b want %b", outs(), 8'b10_10_00_10); end
    cyc();
    total++; if (outs() !== 8'b11_10_10_00) begin bad++; $display("FAIL rd_ack_phase: got %b want %b", outs(), 8'b11_10_10_00); end
    total++; if (bus.rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want BEEF", bus.rdata); end
    bus.cpu_req = 1'b0;
    cyc();
    total++; if (outs() !== 8'b00_00_00_00) begin bad++; $display("FAIL rd_back_idle: got %b want %b", outs(), 8'b00_00_00_00); end
  endtask

  task automatic test_dma_write();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0100; bus.dma_wdata = 16'h1234;
    cyc();
    total++; if (outs() !== 8'b01_01_00_00) begin bad++; $display("FAIL wr_addr_phase: got %b want %b", outs(), 8'b01_01_00_00); end
    total++; if (ram_addr !== 16'h0100 || ram_wdata !== 16'h1234) begin bad++; $display("FAIL wr_ram_bus: got addr=%h wdata=%h want 0100/1234", ram_addr, ram_wdata); end
    cyc();
    total++; if (outs() !== 8'b10_01_00_01) begin bad++; $display("FAIL wr_access_phase: got %b want %b", outs(), 8'b10_01_00_01); end
    cyc();
    total++; if (outs() !== 8'b11_01_01_00) begin bad++; $display("FAIL wr_ack_phase: got %b want %b", outs(), 8'b11_01_01_00); end
    bus.dma_req = 1'b0;
    cyc();
    total++; if (outs() !== 8'b00_00_00_00) begin bad++; $display("FAIL wr_back_idle: got %b want %b", outs(), 8'b00_00_00_00); end
    total++; if (mem[16'h0100] !== 16'h1234) begin bad++; $display("FAIL wr_ram_content: got %h want 1234", mem[16'h0100]); end
    total++; if (bus.rdata !== 16'hBEEF) begin bad++; $display("FAIL wr_rdata_hold: got %h want BEEF", bus.rdata); end
  endtask

  task automatic test_tie_fairness();
    logic [7:0] exp_addr [4];
    logic [15:0] exp_rd [4];
    exp_addr = '{8'b01_10_00_00, 8'b01_01_00_00, 8'b01_10_00_00, 8'b01_01_00_00};
    exp_rd   = '{16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234};
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0100;
    for (int t = 0; t < 4; t++) begin
      cyc();
      total++; if (outs() !== exp_addr[t]) begin bad++; $display("FAIL tie_grant_%0d: got %b want %b", t, outs(), exp_addr[t]); end
      cyc();
      cyc();
      total++; if (bus.rdata !== exp_rd[t]) begin bad++; $display("FAIL tie_rdata_%0d: got %h want %h", t, bus.rdata, exp_rd[t]); end
      if (t == 3) begin
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
      end
      cyc();
      total++; if (arb_state !== 2'd0) begin bad++; $display("FAIL tie_idle_%0d: got %0d want 0", t, arb_state); end
    end
  endtask

  task automatic test_req_drop();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_wdata = 16'h5A5A;
    cyc();
    total++; if (outs() !== 8'b01_10_00_00) begin bad++; $display("FAIL drop_addr_phase: got %b want %b", outs(), 8'b01_10_00_00); end
    bus.cpu_req = 1'b0;
    cyc();
    total++; if (outs() !== 8'b10_10_00_01) begin bad++; $display("FAIL drop_access_phase: got %b want %b", outs(), 8'b10_10_00_01); end
    cyc();
    total++; if (outs() !== 8'b11_10_10_00) begin bad++; $display("FAIL drop_ack_phase: got %b want %b", outs(), 8'b11_10_10_00); end
    cyc();
    cyc();
    total++; if (outs() !== 8'b00_00_00_00) begin bad++; $display("FAIL drop_no_regrant: got %b want %b", outs(), 8'b00_00_00_00); end
    total++; if (mem[16'h0200] !== 16'h5A5A) begin bad++; $display("FAIL drop_ram_content: got %h want 5A5A", mem[16'h0200]); end
  endtask

  task automatic test_reset_mid_op();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0300; bus.dma_wdata = 16'hA5A5;
    cyc();
    cyc();
    total++; if (outs() !== 8'b10_01_00_01) begin bad++; $display("FAIL rstmid_access: got %b want %b", outs(), 8'b10_01_00_01); end
    rst = 1'b1; bus.dma_req = 1'b0;
    cyc();
    total++; if (outs() !== 8'b00_00_00_00) begin bad++; $display("FAIL rstmid_outs: got %b want %b", outs(), 8'b00_00_00_00); end
    total++; if (ram_addr !== 16'h0000 || bus.rdata !== 16'h0000) begin bad++; $display("FAIL rstmid_regs: got addr=%h rdata=%h want 0000/0000", ram_addr, bus.rdata); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (outs() !== 8'b00_00_00_00) begin bad++; $display("FAIL rstmid_no_ack_%0d: got %b want %b", i, outs(), 8'b00_00_00_00); end
    end
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    logic [7:0] exp_addr [4];
    exp_addr = '{8'b01_10_00_00, 8'b01_10_00_00, 8'b01_10_00_00, 8'b01_01_00_00};
    cpu_lock = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0100;
    for (int t = 0; t < 4; t++) begin
      cyc();
      total++; if (outs() !== exp_addr[t]) begin bad++; $display("FAIL lock_grant_%0d: got %b want %b", t, outs(), exp_addr[t]); end
      cyc();
      cyc();
      if (t == 2) cpu_lock = 1'b0;
      if (t == 3) begin
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
      end
      cyc();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pre_en = 1'b0; pre_addr = 16'h0000; pre_data = 16'h0000;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 16'h0000; bus.dma_wdata = 16'h0000;
`ifdef MEM_ARB_LOCK_EN
    cpu_lock = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_tie_fairness();
    test_req_drop();
    test_reset_mid_op();
`ifdef MEM_ARB_LOCK_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port data RAM. It shares the RAM between the control unit's memory path (CPU port) and the I/O DMA engine (DMA port). Each granted request runs through a fixed address/access/acknowledge sequence. Round-robin selection breaks ties, so neither requester starves. The block sits between both requesters and the RAM's address, data and strobe pins, and replaces the direct AM-to-RAM connection.

## Interface
- word_width, 16, data width of the RAM and both ports
- addr_width, 16, RAM address width
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req / dma_req  in  1  request; held high until the matching ack
- cpu_we / dma_we  in  1  1 = write, 0 = read; sampled with the request
- cpu_addr / dma_addr  in  addr_width  access address
- cpu_wdata / dma_wdata  in  word_width  write data
- cpu_grant / dma_grant  out  1  high while that port owns the RAM (states ADDR, ACCESS, ACK)
- cpu_ack / dma_ack  out  1  one-cycle completion pulse
- rdata  out  word_width  last read word; holds its value until the next read completes
- ram_addr  out  addr_width  latched address
- ram_wdata  out  word_width  latched write data
- ram_oe / ram_we  out  1  RAM read and write strobes
- ram_rdata  in  word_width  RAM read data, valid while ram_oe is high
- arb_state  out  2  current state, for display/debug
- cpu_lock  in  1  present only with MEM_ARB_LOCK_EN

## Operation
- States: IDLE=0, ADDR=1, ACCESS=2, ACK=3.
- Registers: owner (0 = CPU, 1 = DMA), last (previous owner), addr_q, wdata_q, we_q, rdata_q.
- IDLE:
  - Neither req high: stay in IDLE.
  - Exactly one req high: that port wins.
  - Both req high: the port that is not last wins.
  - On a win: latch owner and the winner's we/addr/wdata, then go to ADDR.
- ADDR: ram_addr = addr_q; no strobes; go to ACCESS.
- ACCESS:
  - Read: ram_oe=1, and rdata_q <= ram_rdata at the end of the cycle.
  - Write: ram_we=1 with ram_wdata = wdata_q.
  - Go to ACK.
- ACK: owner's ack=1; last <= owner; go to IDLE.
- A request dropped after being latched does not abort the transaction. It completes and ack still pulses.
- A request that is still high in the IDLE cycle after its ack is treated as a new request.
- The non-owner's req is ignored until the arbiter is back in IDLE.
- ram_addr and ram_wdata always reflect addr_q/wdata_q. They change only on the IDLE→ADDR transition.
- Grant, ack, ram_oe and ram_we are decoded from state and owner. They are glitch-free Moore outputs.

## Timing
- Reset values:
  - state=IDLE, owner=0, last=DMA (so the CPU wins the first tie)
  - addr_q, wdata_q, rdata_q = 0; we_q=0
  - all grants, acks and strobes = 0; arb_state=0
- Latency: req sampled high at edge k → grant from k+1 → strobe during cycle k+2 → ack during cycle k+3 → IDLE at k+4.
- Each access takes exactly 4 cycles. Back-to-back requests from the same port get 1 access per 4 cycles.
- With both ports requesting continuously, grants alternate CPU, DMA, CPU, …
- rst asserted in any state: on the next edge, state=IDLE and every strobe, grant and ack drops. A write in progress is cut after its current cycle. No ack is issued for an aborted transaction.
- Addresses are used unmodified; there is no wrap or range check.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - The cpu_lock port exists.
  - If cpu_lock is high during a CPU-owned ACK, the arbiter enters a locked mode. In locked mode, IDLE grants only the CPU and ignores dma_req for as long as cpu_lock stays high.
  - Dropping cpu_lock restores round-robin, with last = CPU.
  - Locking lets the CPU do atomic read-modify-write.
- MEM_ARB_LOCK_EN undefined: no cpu_lock port; pure round-robin.

## Test plan
- CPU read: reset, preload RAM[0x0040]=0xBEEF, pulse cpu_req with we=0 and addr=0x0040 → cpu_grant at k+1, ram_oe at k+2, cpu_ack at k+3, rdata=0xBEEF.
- DMA write: dma_req, we=1, addr=0x0100, wdata=0x1234 → single-cycle ram_we at k+2, dma_ack at k+3, RAM[0x0100]=0x1234; cpu_ack never rises.
- Tie fairness: both ports request for 4 transactions → order CPU, DMA, CPU, DMA, one transaction per 4 cycles.
- Request drop: cpu_req high for 1 cycle only → transaction completes with cpu_ack at k+3 and no second grant.
- Reset mid-op: rst asserted during a DMA-write ACCESS → next cycle state=IDLE, all outputs 0, no dma_ack.
- Lock (MEM_ARB_LOCK_EN): cpu_lock high with both ports requesting → 3 consecutive CPU grants; on lock release the DMA is granted next.
